// File: rtl/log_lane_ctrl.sv
// One river lane of scrolling logs: frame-paced lane position, per-pixel
// sprite-ROM addressing for the VGA scan, and frog-on-log detection.
module log_lane_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int LOG_W     = 96,
  parameter int LOG_H     = 24,
  parameter int NUM_LOGS  = 3,
  parameter int SPACING   = 240,
  parameter int LANE_Y    = 120,
  parameter int SPEED     = 2,
  parameter int FRAME_DIV = 2,
  parameter int DIR       = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       pause,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] frog_x,
  input  logic [9:0] frog_y,
  output logic [6:0] DX,
  output logic [6:0] DY,
  output logic       log_on,
  output logic       dir,
  output logic       frog_on_log,
  output logic       carry_pulse
);

  localparam logic [10:0] C_WRAP     = 11'(SCREEN_W + LOG_W);
  localparam logic [10:0] C_LOG_W    = 11'(LOG_W);
  localparam logic [10:0] C_SPEED    = 11'(SPEED);
  localparam logic [9:0]  C_LANE_Y   = 10'(LANE_Y);
  localparam logic [9:0]  C_LANE_END = 10'(LANE_Y + LOG_H);
  localparam logic [3:0]  C_DIV_LAST = 4'(FRAME_DIV - 1);

  logic        r_fs1, r_fs2, r_fs3;
  logic [3:0]  r_div;
  logic [10:0] r_p;
  logic        r_carry;
  logic        r_log_on;
  logic [6:0]  r_dx, r_dy;
  logic        r_frog;

  logic        w_tick, w_step;
  logic [10:0] w_p_fwd, w_p_bwd;
  logic [10:0] w_left, w_rel_px, w_rel_frog;
  logic        w_pix_hit, w_frog_hit;
  logic [6:0]  w_pix_rel, w_dy;
  logic        w_pix_row, w_frog_row, w_pix_on;

  function automatic logic [10:0] wrap1(input logic [10:0] v);
    return (v >= C_WRAP) ? v - C_WRAP : v;
  endfunction

  // Input range needs up to two wrap subtracts to land in 0..WRAP-1.
  function automatic logic [10:0] rel_of(input logic [9:0] x, input logic [10:0] left);
    logic [10:0] t;
    t = {1'b0, x} + C_LOG_W + C_WRAP - left;
    t = wrap1(t);
    return wrap1(t);
  endfunction

  assign w_tick  = r_fs2 & ~r_fs3;
  assign w_step  = w_tick & ~pause & (r_div == C_DIV_LAST);
  assign w_p_fwd = wrap1(r_p + C_SPEED);
  assign w_p_bwd = (r_p >= C_SPEED) ? r_p - C_SPEED : r_p + C_WRAP - C_SPEED;

  // Descending scan so the lowest-index hit overwrites any later one.
  always_comb begin
    w_pix_hit  = 1'b0;
    w_pix_rel  = '0;
    w_frog_hit = 1'b0;
    w_left     = '0;
    w_rel_px   = '0;
    w_rel_frog = '0;
    for (int i = NUM_LOGS - 1; i >= 0; i--) begin
      w_left     = wrap1(r_p + 11'(i * SPACING));
      w_rel_px   = rel_of(DrawX, w_left);
      w_rel_frog = rel_of(frog_x, w_left);
      if (w_rel_px < C_LOG_W) begin
        w_pix_hit = 1'b1;
        w_pix_rel = 7'(w_rel_px);
      end
      if (w_rel_frog < C_LOG_W) w_frog_hit = 1'b1;
    end
  end

  assign w_pix_row  = (DrawY >= C_LANE_Y) && (DrawY < C_LANE_END);
  assign w_frog_row = (frog_y >= C_LANE_Y) && (frog_y < C_LANE_END);
  assign w_pix_on   = w_pix_row & w_pix_hit;
  assign w_dy       = 7'(DrawY - C_LANE_Y);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fs1    <= 1'b0;
      r_fs2    <= 1'b0;
      r_fs3    <= 1'b0;
      r_div    <= '0;
      r_p      <= '0;
      r_carry  <= 1'b0;
      r_log_on <= 1'b0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_frog   <= 1'b0;
    end else begin
      r_fs1 <= frame_clk;
      r_fs2 <= r_fs1;
      r_fs3 <= r_fs2;
      if (w_tick && !pause) r_div <= (r_div == C_DIV_LAST) ? 4'd0 : r_div + 4'd1;
      if (w_step) r_p <= (DIR != 0) ? w_p_bwd : w_p_fwd;
      r_carry  <= w_step;
      r_log_on <= w_pix_on;
      r_dx     <= w_pix_on ? w_pix_rel : 7'd0;
      r_dy     <= w_pix_on ? w_dy : 7'd0;
      r_frog   <= w_frog_row & w_frog_hit;
    end
  end

  assign DX          = r_dx;
  assign DY          = r_dy;
  assign log_on      = r_log_on;
  assign dir         = (DIR != 0);
  assign frog_on_log = r_frog;
  assign carry_pulse = r_carry;

endmodule
